// File: rtl/execute_stage_mdu.sv
// rtl/execute_stage_mdu.sv - RV64 execute stage: forwarding, ALU, branch, E/M register, iterative MDU
//
// Purpose: forwarding muxes, single-cycle ALU, branch resolution, PC-target adder and the
// E/M pipeline register. With EXECUTE_MDU_EN defined, an iterative radix-2 multiply/divide
// unit (M extension) is added. It holds the front of the pipeline through o_stall_e until
// its result is ready. Without the macro, i_mdu is ignored and o_stall_e is tied low.
//
// Ports:
//   i_clk, i_arst                 clock, synchronous active-high reset
//   i_valid, i_flush              E-stage instruction valid / kill
//   i_pc, i_pc_plus4              instruction PC and PC+4
//   i_rs1/rs2_data, i_imm_ext     register operands and extended immediate
//   i_rs1/rs2/rd_addr             register addresses (passed through to hazard unit)
//   i_func3                       branch condition / MDU op select
//   i_result_src, i_alu_control   writeback select (passed through), ALU op
//   i_mem_we, i_reg_we, i_alu_src, i_branch, i_jump, i_mdu   control
//   i_result, i_alu_result        forwarding sources from W and M
//   i_forward_rs1/rs2_exec        0 regfile, 1 i_result, 2 i_alu_result
//   o_stall_e                     hold F/D/E while the MDU works
//   o_pc_src, o_pc_target         redirect (combinational)
//   o_*_m / o_*_preg / o_*        E/M register outputs
//
// i_alu_control encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu,
//   7 sll, 8 srl, 9 sra, 10 pass SrcB; any other code yields 0.

module execute_stage_mdu #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_valid,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    input  logic [2:0]            i_func3,
    input  logic [2:0]            i_result_src,
    input  logic [4:0]            i_alu_control,
    input  logic                  i_mem_we,
    input  logic                  i_reg_we,
    input  logic                  i_alu_src,
    input  logic                  i_branch,
    input  logic                  i_jump,
    input  logic                  i_mdu,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [1:0]            i_forward_rs1_exec,
    input  logic [1:0]            i_forward_rs2_exec,
    output logic                  o_stall_e,
    output logic                  o_pc_src,
    output logic [ADDR_WIDTH-1:0] o_pc_target,
    output logic [REG_ADDR_W-1:0] o_rs1_addr,
    output logic [REG_ADDR_W-1:0] o_rs2_addr,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_valid_m,
    output logic [2:0]            o_result_src,
    output logic                  o_mem_we,
    output logic                  o_reg_we,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target_preg,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic [REG_ADDR_W-1:0] o_rd_addr_preg
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_SLL   = 5'd7;
    localparam logic [4:0] ALU_SRL   = 5'd8;
    localparam logic [4:0] ALU_SRA   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    // ------------------------------------------------------------------
    // Operand select
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] write_data;

    always_comb begin
        case (i_forward_rs1_exec)
            2'd1:    src_a = i_result;
            2'd2:    src_a = i_alu_result;
            default: src_a = i_rs1_data;
        endcase
        case (i_forward_rs2_exec)
            2'd1:    write_data = i_result;
            2'd2:    write_data = i_alu_result;
            default: write_data = i_rs2_data;
        endcase
        src_b = i_alu_src ? i_imm_ext : write_data;
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] alu_out;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (i_alu_control)
            ALU_ADD:   alu_out = src_a + src_b;
            ALU_SUB:   alu_out = src_a - src_b;
            ALU_AND:   alu_out = src_a & src_b;
            ALU_OR:    alu_out = src_a | src_b;
            ALU_XOR:   alu_out = src_a ^ src_b;
            ALU_SLT:   alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU:  alu_out = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:   alu_out = src_a << shamt;
            ALU_SRL:   alu_out = src_a >> shamt;
            ALU_SRA:   alu_out = $signed(src_a) >>> shamt;
            ALU_PASSB: alu_out = src_b;
            default:   alu_out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch resolution and target
    // ------------------------------------------------------------------
    logic br_eq;
    logic br_lt;
    logic br_ltu;
    logic br_taken;

    always_comb begin
        br_eq  = (src_a == write_data);
        br_lt  = ($signed(src_a) < $signed(write_data));
        br_ltu = (src_a < write_data);
        case (i_func3)
            3'd0:    br_taken = br_eq;
            3'd1:    br_taken = ~br_eq;
            3'd4:    br_taken = br_lt;
            3'd5:    br_taken = ~br_lt;
            3'd6:    br_taken = br_ltu;
            3'd7:    br_taken = ~br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign o_pc_target = i_pc + ADDR_WIDTH'(i_imm_ext);
    assign o_pc_src    = i_valid & (i_jump | (i_branch & br_taken));

    assign o_rs1_addr = i_rs1_addr;
    assign o_rs2_addr = i_rs2_addr;
    assign o_rd_addr  = i_rd_addr;

    // ------------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------------
    logic                  stall;
    logic                  mdu_done;
    logic [DATA_WIDTH-1:0] mdu_result;

`ifdef EXECUTE_MDU_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    mdu_state_e            state_q, state_d;
    logic [SHW-1:0]        cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  res_neg_q, res_neg_d;
    // acc: product high half / partial remainder; lo: product low half / quotient;
    // opb: multiplicand / divisor magnitude.
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;

    logic                  start;
    logic                  sign_a;
    logic                  sign_b;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  cap_neg;

    assign start = i_valid & i_mdu & ~i_flush;

    // Operand conditioning at accept: both units work on magnitudes, the sign is
    // re-applied once in DONE.
    always_comb begin
        sign_a = (i_func3 == 3'd1) | (i_func3 == 3'd2) | (i_func3 == 3'd4) | (i_func3 == 3'd6);
        sign_b = (i_func3 == 3'd1) | (i_func3 == 3'd4) | (i_func3 == 3'd6);
        a_neg  = sign_a & src_a[DATA_WIDTH-1];
        b_neg  = sign_b & write_data[DATA_WIDTH-1];
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -write_data : write_data;
        if (!i_func3[2]) begin
            cap_neg = a_neg ^ b_neg;
        end else if (!i_func3[1]) begin
            // Divide by zero keeps the raw all-ones quotient.
            cap_neg = (a_neg ^ b_neg) & (write_data != '0);
        end else begin
            // Remainder takes the sign of the dividend.
            cap_neg = a_neg;
        end
    end

    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH+1:0] div_diff;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q, lo_q[DATA_WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        res_neg_d = res_neg_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_BUSY;
                        cnt_d     = '0;
                        op_d      = i_func3;
                        res_neg_d = cap_neg;
                        acc_d     = '0;
                        lo_d      = a_mag;
                        opb_d     = b_mag;
                    end
                end
                ST_BUSY: begin
                    if (op_q[2]) begin
                        // Restoring divide: keep the trial difference only if it did not borrow.
                        if (div_diff[DATA_WIDTH+1]) begin
                            acc_d = div_shift[DATA_WIDTH-1:0];
                            lo_d  = {lo_q[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            acc_d = div_diff[DATA_WIDTH-1:0];
                            lo_d  = {lo_q[DATA_WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        // Shift-add multiply: {acc, lo} shifts right with the adder carry on top.
                        acc_d = mul_sum[DATA_WIDTH:1];
                        lo_d  = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
                    end
                    if (cnt_q == SHW'(DATA_WIDTH-1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + SHW'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            res_neg_q <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            res_neg_q <= res_neg_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
        end
    end

    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] prod_fix;

    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = res_neg_q ? -prod : prod;
        case (op_q)
            3'd0:              mdu_result = lo_q;
            3'd1, 3'd2, 3'd3:  mdu_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'd4, 3'd5:        mdu_result = res_neg_q ? -lo_q : lo_q;
            default:           mdu_result = res_neg_q ? -acc_q : acc_q;
        endcase
    end

    assign stall    = ((state_q == ST_IDLE) & start) | (state_q == ST_BUSY);
    assign mdu_done = (state_q == ST_DONE);
`else
    // No MDU: i_mdu has no effect and the stage never stalls.
    assign stall      = i_mdu & 1'b0;
    assign mdu_done   = 1'b0;
    assign mdu_result = '0;
`endif

    assign o_stall_e = stall;

    // ------------------------------------------------------------------
    // E/M pipeline register
    // ------------------------------------------------------------------
    logic                  valid_m_q, valid_m_d;
    logic [2:0]            result_src_q, result_src_d;
    logic                  mem_we_q, mem_we_d;
    logic                  reg_we_q, reg_we_d;
    logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic [ADDR_WIDTH-1:0] pc_target_q, pc_target_d;
    logic [DATA_WIDTH-1:0] imm_ext_q, imm_ext_d;
    logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_comb begin
        // Bubbles only clear the qualifying bits; data fields load regardless.
        valid_m_d    = i_valid;
        mem_we_d     = i_mem_we;
        reg_we_d     = i_reg_we;
        if (stall | i_flush) begin
            valid_m_d = 1'b0;
            mem_we_d  = 1'b0;
            reg_we_d  = 1'b0;
        end
        result_src_d = i_result_src;
        pc_plus4_d   = i_pc_plus4;
        pc_target_d  = o_pc_target;
        imm_ext_d    = i_imm_ext;
        alu_result_d = mdu_done ? mdu_result : alu_out;
        write_data_d = write_data;
        rd_addr_d    = i_rd_addr;
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            valid_m_q    <= 1'b0;
            result_src_q <= '0;
            mem_we_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            pc_plus4_q   <= '0;
            pc_target_q  <= '0;
            imm_ext_q    <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_addr_q    <= '0;
        end else begin
            valid_m_q    <= valid_m_d;
            result_src_q <= result_src_d;
            mem_we_q     <= mem_we_d;
            reg_we_q     <= reg_we_d;
            pc_plus4_q   <= pc_plus4_d;
            pc_target_q  <= pc_target_d;
            imm_ext_q    <= imm_ext_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign o_valid_m        = valid_m_q;
    assign o_result_src     = result_src_q;
    assign o_mem_we         = mem_we_q;
    assign o_reg_we         = reg_we_q;
    assign o_pc_plus4       = pc_plus4_q;
    assign o_pc_target_preg = pc_target_q;
    assign o_imm_ext        = imm_ext_q;
    assign o_alu_result     = alu_result_q;
    assign o_write_data     = write_data_q;
    assign o_rd_addr_preg   = rd_addr_q;

endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb/tb_execute_stage_mdu.sv - self-checking bench for execute_stage_mdu
module tb_execute_stage_mdu;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_arst = 1'b1;
    logic          i_valid = 1'b0, i_flush = 1'b0;
    logic [AW-1:0] i_pc = '0, i_pc_plus4 = '0;
    logic [DW-1:0] i_rs1_data = '0, i_rs2_data = '0, i_imm_ext = '0;
    logic [RW-1:0] i_rs1_addr = '0, i_rs2_addr = '0, i_rd_addr = '0;
    logic [2:0]    i_func3 = '0, i_result_src = '0;
    logic [4:0]    i_alu_control = '0;
    logic          i_mem_we = 1'b0, i_reg_we = 1'b0, i_alu_src = 1'b0;
    logic          i_branch = 1'b0, i_jump = 1'b0, i_mdu = 1'b0;
    logic [DW-1:0] i_result = '0, i_alu_result = '0;
    logic [1:0]    i_forward_rs1_exec = '0, i_forward_rs2_exec = '0;

    logic          o_stall_e, o_pc_src, o_valid_m, o_mem_we, o_reg_we;
    logic [AW-1:0] o_pc_target, o_pc_plus4, o_pc_target_preg;
    logic [RW-1:0] o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_addr_preg;
    logic [2:0]    o_result_src;
    logic [DW-1:0] o_imm_ext, o_alu_result, o_write_data;

    execute_stage_mdu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_W(RW)) dut (
        .i_clk(clk), .i_arst(i_arst), .i_valid(i_valid), .i_flush(i_flush),
        .i_pc(i_pc), .i_pc_plus4(i_pc_plus4),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_imm_ext(i_imm_ext), .i_func3(i_func3), .i_result_src(i_result_src),
        .i_alu_control(i_alu_control), .i_mem_we(i_mem_we), .i_reg_we(i_reg_we),
        .i_alu_src(i_alu_src), .i_branch(i_branch), .i_jump(i_jump), .i_mdu(i_mdu),
        .i_result(i_result), .i_alu_result(i_alu_result),
        .i_forward_rs1_exec(i_forward_rs1_exec), .i_forward_rs2_exec(i_forward_rs2_exec),
        .o_stall_e(o_stall_e), .o_pc_src(o_pc_src), .o_pc_target(o_pc_target),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
        .o_valid_m(o_valid_m), .o_result_src(o_result_src), .o_mem_we(o_mem_we),
        .o_reg_we(o_reg_we), .o_pc_plus4(o_pc_plus4), .o_pc_target_preg(o_pc_target_preg),
        .o_imm_ext(o_imm_ext), .o_alu_result(o_alu_result), .o_write_data(o_write_data),
        .o_rd_addr_preg(o_rd_addr_preg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference functions ----------------
    function automatic logic [63:0] fwd(input logic [1:0] sel, input logic [63:0] rf);
        if (sel == 2'd1) return i_result;
        if (sel == 2'd2) return i_alu_result;
        return rf;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa;
        sa = a;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd6:  return (a < b) ? 64'd1 : 64'd0;
            5'd7:  return a << b[5:0];
            5'd8:  return a >> b[5:0];
            5'd9:  return sa >>> b[5:0];
            5'd10: return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit br_ref(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] mdu_ref(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        ea = {64'd0, a};
        eb = {64'd0, b};
        if (f3 == 3'd1 || f3 == 3'd2) ea = {{64{a[63]}}, a};
        if (f3 == 3'd1) eb = {{64{b[63]}}, b};
        p = ea * eb;
        case (f3)
            3'd0: return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MINV && b == ONES) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == ONES) return 64'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int          m_busy = 0;      // remaining iteration cycles of an accepted MDU op
    bit          m_done = 1'b0;   // result cycle
    logic [63:0] m_res  = '0;     // result fixed at accept time
    bit          e_full = 1'b1;   // all E/M fields meaningful (not a bubble)
    logic        e_valid = 0, e_reg_we = 0, e_mem_we = 0;
    logic [2:0]  e_rsrc = 0;
    logic [63:0] e_pc4 = 0, e_tgt = 0, e_imm = 0, e_alu = 0, e_wd = 0;
    logic [4:0]  e_rd = 0;
    bit          chk_en = 1'b0;

    function automatic bit exp_stall();
`ifdef EXECUTE_MDU_EN
        return (m_busy > 0) || (!m_done && i_valid && i_mdu && !i_flush);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] a, wd, sb;
        bit st;
        a  = fwd(i_forward_rs1_exec, i_rs1_data);
        wd = fwd(i_forward_rs2_exec, i_rs2_data);
        sb = i_alu_src ? i_imm_ext : wd;
        st = exp_stall();
        if (i_arst) begin
            m_busy = 0; m_done = 0; e_full = 1;
            e_valid = 0; e_reg_we = 0; e_mem_we = 0; e_rsrc = 0;
            e_pc4 = 0; e_tgt = 0; e_imm = 0; e_alu = 0; e_wd = 0; e_rd = 0;
        end else begin
            e_full   = !st && !i_flush;
            e_valid  = i_valid && e_full;
            e_reg_we = i_reg_we && e_full;
            e_mem_we = i_mem_we && e_full;
            e_rsrc = i_result_src; e_pc4 = i_pc_plus4; e_tgt = i_pc + i_imm_ext;
            e_imm = i_imm_ext; e_wd = wd; e_rd = i_rd_addr;
            e_alu = m_done ? m_res : alu_ref(i_alu_control, a, sb);
`ifdef EXECUTE_MDU_EN
            if (i_flush) begin
                m_busy = 0; m_done = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_done = 1;
            end else if (m_done) begin
                m_done = 0;
            end else if (i_valid && i_mdu) begin
                m_busy = DW;
                m_res  = mdu_ref(i_func3, a, wd);
            end
`endif
        end
    end

    always @(negedge clk) begin : compare
        logic [63:0] a, wd;
        a  = fwd(i_forward_rs1_exec, i_rs1_data);
        wd = fwd(i_forward_rs2_exec, i_rs2_data);
        if (chk_en) begin
            chk("stall", 64'(o_stall_e), 64'(exp_stall()));
            chk("pc_src", 64'(o_pc_src), 64'(i_valid && (i_jump || (i_branch && br_ref(i_func3, a, wd)))));
            chk("pc_target", o_pc_target, i_pc + i_imm_ext);
            chk("rd_pass", 64'(o_rd_addr), 64'(i_rd_addr));
            chk("valid_m", 64'(o_valid_m), 64'(e_valid));
            chk("reg_we_m", 64'(o_reg_we), 64'(e_reg_we));
            chk("mem_we_m", 64'(o_mem_we), 64'(e_mem_we));
            if (e_full) begin
                chk("alu_result_m", o_alu_result, e_alu);
                chk("write_data_m", o_write_data, e_wd);
                chk("pc_plus4_m", o_pc_plus4, e_pc4);
                chk("pc_target_m", o_pc_target_preg, e_tgt);
                chk("imm_m", o_imm_ext, e_imm);
                chk("rsrc_m", 64'(o_result_src), 64'(e_rsrc));
                chk("rd_m", 64'(o_rd_addr_preg), 64'(e_rd));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // All tasks start and end at posedge+1.
    task automatic alu_op(input string nm, input logic [4:0] op, input logic [1:0] f1, input logic [1:0] f2,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic asrc,
                          input logic [63:0] imm, input logic [63:0] exp);
        i_valid = 1; i_mdu = 0; i_branch = 0; i_jump = 0; i_reg_we = 1; i_mem_we = 0;
        i_alu_control = op; i_forward_rs1_exec = f1; i_forward_rs2_exec = f2;
        i_rs1_data = rs1; i_rs2_data = rs2; i_alu_src = asrc; i_imm_ext = imm;
        i_pc = 64'h1000; i_pc_plus4 = 64'h1004; i_rd_addr = 5'd3; i_result_src = 3'd1;
        @(posedge clk); #1;
        chk(nm, o_alu_result, exp);
        chk({nm, "_valid"}, 64'(o_valid_m), 64'd1);
        i_valid = 0; i_reg_we = 0; i_forward_rs1_exec = 0; i_forward_rs2_exec = 0; i_alu_src = 0;
    endtask

    task automatic do_mdu(input string nm, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        int stalls;
        bit got;
        i_valid = 1; i_mdu = 1; i_func3 = f3; i_reg_we = 1; i_alu_control = 5'd0; i_alu_src = 0;
        i_forward_rs1_exec = 2'd2; i_alu_result = a; i_rs1_data = ~a;
        i_forward_rs2_exec = 2'd0; i_rs2_data = b; i_rd_addr = 5'd9;
        stalls = 0; got = 0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            if (o_stall_e) stalls++;
            @(posedge clk); #1;
            // operands were captured at accept; later changes must not matter
            i_alu_result = {$urandom, $urandom};
            i_rs1_data   = {$urandom, $urandom};
            i_rs2_data   = {$urandom, $urandom};
            if (o_valid_m) got = 1;
        end
        chk({nm, "_done"}, 64'(got), 64'd1);
        chk({nm, "_stall_cycles"}, 64'(stalls), 64'(DW + 1));
        chk(nm, o_alu_result, exp);
        i_valid = 0; i_mdu = 0; i_reg_we = 0; i_forward_rs1_exec = 0;
    endtask

    typedef struct { logic [2:0] f3; logic [63:0] a; logic [63:0] b; bit taken; } br_vec_t;
    br_vec_t brv[8];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        brv[0] = '{3'd0, 64'd5, 64'd5, 1'b1};
        brv[1] = '{3'd0, 64'd5, 64'd6, 1'b0};
        brv[2] = '{3'd1, 64'd5, 64'd6, 1'b1};
        brv[3] = '{3'd4, ONES, 64'd1, 1'b1};
        brv[4] = '{3'd5, ONES, 64'd1, 1'b0};
        brv[5] = '{3'd6, ONES, 64'd1, 1'b0};
        brv[6] = '{3'd7, ONES, 64'd1, 1'b1};
        brv[7] = '{3'd2, 64'd5, 64'd5, 1'b0};

        @(posedge clk); #1;
        chk_en = 1;
        chk("reset_valid", 64'(o_valid_m), 64'd0);
        chk("reset_alu", o_alu_result, 64'd0);
        chk("reset_stall", 64'(o_stall_e), 64'd0);
        i_arst = 0;
        @(posedge clk); #1;

        // forwarding and ALU
        i_alu_result = 64'd5;
        alu_op("fwd_m_add", 5'd0, 2'd2, 2'd0, 64'd77, 64'd3, 0, 64'd0, 64'd8);
        i_result = 64'd10;
        alu_op("fwd_w_add", 5'd0, 2'd1, 2'd0, 64'd77, 64'd3, 0, 64'd0, 64'd13);
        i_alu_result = 64'd4;
        alu_op("fwd_rs2_sub", 5'd1, 2'd0, 2'd2, 64'd20, 64'd99, 0, 64'd0, 64'd16);
        alu_op("addi", 5'd0, 2'd0, 2'd0, 64'd20, 64'd99, 1, ONES, 64'd19);
        alu_op("slt", 5'd5, 2'd0, 2'd0, ONES, 64'd1, 0, 64'd0, 64'd1);
        alu_op("sltu", 5'd6, 2'd0, 2'd0, ONES, 64'd1, 0, 64'd0, 64'd0);
        alu_op("sra", 5'd9, 2'd0, 2'd0, MINV, 64'd4, 0, 64'd0, 64'hF800_0000_0000_0000);
        alu_op("srl", 5'd8, 2'd0, 2'd0, MINV, 64'd4, 0, 64'd0, 64'h0800_0000_0000_0000);

        // branch resolution
        for (int k = 0; k < 8; k++) begin
            i_valid = 1; i_branch = 1; i_func3 = brv[k].f3;
            i_rs1_data = brv[k].a; i_rs2_data = brv[k].b;
            i_pc = 64'h1000; i_imm_ext = 64'h20;
            #1;
            chk($sformatf("branch_%0d", k), 64'(o_pc_src), 64'(brv[k].taken));
            chk($sformatf("branch_tgt_%0d", k), o_pc_target, 64'h1020);
            @(posedge clk); #1;
        end
        i_branch = 0; i_jump = 1; i_valid = 0;
        #1 chk("jump_invalid", 64'(o_pc_src), 64'd0);
        i_valid = 1;
        #1 chk("jump_valid", 64'(o_pc_src), 64'd1);
        @(posedge clk); #1;
        i_jump = 0; i_valid = 0;
        @(posedge clk); #1;

`ifdef EXECUTE_MDU_EN
        do_mdu("div", 3'd4, -64'sd7, 64'd2, -64'sd3);
        do_mdu("rem", 3'd6, -64'sd7, 64'd2, ONES);
        do_mdu("divu_zero", 3'd5, 64'h1234_5678, 64'd0, ONES);
        do_mdu("rem_zero", 3'd6, 64'd9, 64'd0, 64'd9);
        do_mdu("div_ovf", 3'd4, MINV, ONES, MINV);
        do_mdu("rem_ovf", 3'd6, MINV, ONES, 64'd0);
        do_mdu("mulhu", 3'd3, ONES, 64'd2, 64'd1);
        do_mdu("mul", 3'd0, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        do_mdu("mulh", 3'd1, ONES, ONES, 64'd0);
        do_mdu("mulhsu", 3'd2, ONES, 64'd2, ONES);
        do_mdu("remu", 3'd7, 64'd100, 64'd7, 64'd2);
        do_mdu("div_zero", 3'd4, -64'sd5, 64'd0, ONES);

        // flush in BUSY cycle 10
        i_valid = 1; i_mdu = 1; i_func3 = 3'd4; i_reg_we = 1; i_rs1_data = 64'd100; i_rs2_data = 64'd7;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1 i_flush = 1;
        @(posedge clk); #1;
        i_flush = 0; i_valid = 0; i_mdu = 0; i_reg_we = 0;
        chk("flush_stall", 64'(o_stall_e), 64'd0);
        chk("flush_valid", 64'(o_valid_m), 64'd0);
        begin
            int wb;
            wb = 0;
            repeat (70) begin
                @(posedge clk); #1;
                if (o_valid_m || o_reg_we) wb++;
            end
            chk("flush_no_wb", 64'(wb), 64'd0);
        end
`else
        // i_mdu ignored: executes as its ALU op in one cycle
        i_valid = 1; i_mdu = 1; i_func3 = 3'd4; i_alu_control = 5'd0; i_reg_we = 1;
        i_rs1_data = 64'd5; i_rs2_data = 64'd3;
        #1 chk("nomdu_stall", 64'(o_stall_e), 64'd0);
        @(posedge clk); #1;
        chk("nomdu_result", o_alu_result, 64'd8);
        chk("nomdu_valid", 64'(o_valid_m), 64'd1);
        i_valid = 0; i_mdu = 0; i_reg_we = 0;
`endif

        // reset mid-operation
        i_valid = 1; i_mdu = 1; i_func3 = 3'd4; i_reg_we = 1; i_rs1_data = 64'd100; i_rs2_data = 64'd7;
        i_pc = 64'h2000; i_pc_plus4 = 64'h2004; i_imm_ext = 64'h40;
        repeat (20) @(posedge clk);
        #1 i_arst = 1;
        @(posedge clk); #1;
        i_arst = 0; i_valid = 0; i_mdu = 0; i_reg_we = 0;
        chk("rst_stall", 64'(o_stall_e), 64'd0);
        chk("rst_valid", 64'(o_valid_m), 64'd0);
        chk("rst_pc4", o_pc_plus4, 64'd0);
        chk("rst_tgt", o_pc_target_preg, 64'd0);
        chk("rst_imm", o_imm_ext, 64'd0);
        @(posedge clk); #1;
        alu_op("post_rst_add", 5'd0, 2'd0, 2'd0, 64'd1, 64'd2, 0, 64'd0, 64'd3);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
